// File: rtl/io_uart_port.sv
// io_uart_port
// Memory-mapped 8N1 UART on the processor IO bus.
//   0x01 W : push byte into TX FIFO (dropped when full)
//   0x01 R : RX FIFO head (0x00 when empty), popped on the read strobe
//   0x02 R : 0xFF when RX FIFO non-empty
//   0x03 R : 0xFF when TX FIFO full
//   0x04 R : {6'b0, frame_err, rx_overrun}, sticky, cleared by the read strobe
//   others : read 0xFF, writes ignored
// Ports:
//   clk100 / reset      : clock, asynchronous active-low reset
//   IO_port_ID          : access address
//   IO_write_data       : write data
//   IO_write_strobe     : one write per high cycle
//   IO_read_strobe      : one read per high cycle (side effects only)
//   IO_read_data        : combinational read decode
//   uart_rxd / uart_txd : serial in (asynchronous) / serial out (registered)
module io_uart_port #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [15:0]    C_BIT_END   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]    C_HALF_END  = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- address decode ----------------
  logic w_sel_data, w_sel_stat;
  assign w_sel_data = (IO_port_ID == 8'h01);
  assign w_sel_stat = (IO_port_ID == 8'h04);

  // ---------------- TX FIFO ----------------
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
  logic [TX_AW:0]   r_tx_count;
  logic             w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [7:0]       w_tx_head;

  assign w_tx_full  = (r_tx_count == TX_FULL_CNT);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_head  = r_tx_mem[r_tx_rd_ptr];
  // A write into a full FIFO is still accepted when the serialiser frees a slot on the same edge.
  assign w_tx_push  = IO_write_strobe & w_sel_data & (~w_tx_full | w_tx_pop);

  always_ff @(posedge clk100) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= IO_write_data;
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  state_t      r_tx_state, w_tx_state_next;
  logic [15:0] r_tx_cnt, w_tx_cnt_next;
  logic [2:0]  r_tx_bit, w_tx_bit_next;
  logic [7:0]  r_tx_shift, w_tx_shift_next;
  logic        r_txd, w_txd_next;
  logic        w_tx_bit_done;

  assign w_tx_bit_done = (r_tx_cnt == C_BIT_END);

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx_shift <= w_tx_shift_next;
      r_txd      <= w_txd_next;
    end
  end

  // r_txd is the registered line level, so each branch sets the level of the bit being entered.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt + 16'd1;
    w_tx_bit_next   = r_tx_bit;
    w_tx_shift_next = r_tx_shift;
    w_txd_next      = r_txd;
    w_tx_pop        = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_cnt_next = '0;
        w_txd_next    = 1'b1;
        if (!w_tx_empty) begin
          w_tx_pop        = 1'b1;
          w_tx_shift_next = w_tx_head;
          w_txd_next      = 1'b0;
          w_tx_state_next = S_START;
        end
      end
      S_START: begin
        if (w_tx_bit_done) begin
          w_tx_cnt_next   = '0;
          w_tx_bit_next   = '0;
          w_txd_next      = r_tx_shift[0];
          w_tx_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tx_bit_done) begin
          w_tx_cnt_next   = '0;
          w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
          if (r_tx_bit == 3'd7) begin
            w_txd_next      = 1'b1;
            w_tx_state_next = S_STOP;
          end else begin
            w_tx_bit_next = r_tx_bit + 3'd1;
            w_txd_next    = r_tx_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_tx_bit_done) begin
          w_tx_cnt_next = '0;
          // Chain straight into the next start bit so back-to-back frames have no idle gap.
          if (!w_tx_empty) begin
            w_tx_pop        = 1'b1;
            w_tx_shift_next = w_tx_head;
            w_txd_next      = 1'b0;
            w_tx_state_next = S_START;
          end else begin
            w_txd_next      = 1'b1;
            w_tx_state_next = S_IDLE;
          end
        end
      end
      default: w_tx_state_next = S_IDLE;
    endcase
  end

  assign uart_txd = r_txd;

  // ---------------- RX synchroniser ----------------
  logic r_rx_sync1, r_rx_sync2;
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= uart_rxd;
      r_rx_sync2 <= r_rx_sync1;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
  logic [RX_AW:0]   r_rx_count;
  logic             w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_push_req;
  logic [7:0]       w_rx_head, r_rx_shift;

  assign w_rx_full  = (r_rx_count == RX_FULL_CNT);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_head  = r_rx_mem[r_rx_rd_ptr];
  assign w_rx_pop   = IO_read_strobe & w_sel_data & ~w_rx_empty;
  assign w_rx_push  = w_rx_push_req & (~w_rx_full | w_rx_pop);

  always_ff @(posedge clk100) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // ---------------- RX FSM ----------------
  state_t      r_rx_state, w_rx_state_next;
  logic [15:0] r_rx_cnt, w_rx_cnt_next;
  logic [2:0]  r_rx_bit, w_rx_bit_next;
  logic [7:0]  w_rx_shift_next;
  logic        w_frame_err_set;

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_shift <= w_rx_shift_next;
    end
  end

  // The half-bit wait in START aligns every later full-bit wait onto a bit centre.
  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt + 16'd1;
    w_rx_bit_next   = r_rx_bit;
    w_rx_shift_next = r_rx_shift;
    w_rx_push_req   = 1'b0;
    w_frame_err_set = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        w_rx_cnt_next = '0;
        if (!r_rx_sync2) w_rx_state_next = S_START;
      end
      S_START: begin
        if (r_rx_cnt == C_HALF_END) begin
          w_rx_cnt_next   = '0;
          w_rx_bit_next   = '0;
          w_rx_state_next = r_rx_sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == C_BIT_END) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {r_rx_sync2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_next = S_STOP;
          else                  w_rx_bit_next   = r_rx_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == C_BIT_END) begin
          w_rx_cnt_next   = '0;
          w_rx_push_req   = r_rx_sync2;
          w_frame_err_set = ~r_rx_sync2;
          w_rx_state_next = S_IDLE;
        end
      end
      default: w_rx_state_next = S_IDLE;
    endcase
  end

  // ---------------- sticky status ----------------
  logic r_frame_err, r_rx_overrun, w_flag_clr, w_overrun_set;
  assign w_flag_clr    = IO_read_strobe & w_sel_stat;
  assign w_overrun_set = w_rx_push_req & w_rx_full & ~w_rx_pop;

  // Set has priority over a clear on the same edge.
  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_frame_err  <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_frame_err  <= (r_frame_err & ~w_flag_clr) | w_frame_err_set;
      r_rx_overrun <= (r_rx_overrun & ~w_flag_clr) | w_overrun_set;
    end
  end

  // ---------------- read decode ----------------
  always_comb begin
    IO_read_data = 8'hFF;
    case (IO_port_ID)
      8'h01:   IO_read_data = w_rx_empty ? 8'h00 : w_rx_head;
      8'h02:   IO_read_data = w_rx_empty ? 8'h00 : 8'hFF;
      8'h03:   IO_read_data = w_tx_full ? 8'hFF : 8'h00;
      8'h04:   IO_read_data = {6'b0, r_frame_err, r_rx_overrun};
      default: IO_read_data = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_io_uart_port.sv
module tb_io_uart_port;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk100, reset;
  logic [7:0] IO_port_ID, IO_write_data, IO_read_data;
  logic       IO_write_strobe, IO_read_strobe, uart_rxd, uart_txd;

  int n_checks = 0;
  int n_pass   = 0;

  io_uart_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk100(clk100), .reset(reset), .IO_port_ID(IO_port_ID),
    .IO_write_data(IO_write_data), .IO_write_strobe(IO_write_strobe),
    .IO_read_strobe(IO_read_strobe), .IO_read_data(IO_read_data),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // All bus tasks are entered between clock edges; strobes span exactly one rising edge.
  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    IO_port_ID = port; IO_write_data = data; IO_write_strobe = 1'b1;
    @(negedge clk100);
    IO_write_strobe = 1'b0;
    $display("WR port=%02h data=%02h", port, data);
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] data);
    IO_port_ID = port; IO_read_strobe = 1'b1;
    #1 data = IO_read_data;
    @(negedge clk100);
    IO_read_strobe = 1'b0;
    $display("RD port=%02h data=%02h", port, data);
  endtask

  task automatic peek(input logic [7:0] port, output logic [7:0] data);
    IO_port_ID = port;
    #1 data = IO_read_data;
  endtask

  task automatic uart_send(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      repeat (CPB) @(negedge clk100);
    end
    $display("RXD frame data=%02h stop=%0d", data, stop);
  endtask

  // Finds the next start bit, then samples each bit near its centre.
  task automatic tx_capture(output logic [7:0] data, output logic stop_bit, output logic found);
    int waited;
    data = '0; stop_bit = 1'b0; found = 1'b0; waited = 0;
    while (uart_txd !== 1'b0 && waited < 400) begin
      @(negedge clk100);
      waited++;
    end
    if (uart_txd === 1'b0) begin
      found = 1'b1;
      repeat (2) @(negedge clk100);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk100);
        data[i] = uart_txd;
      end
      repeat (CPB) @(negedge clk100);
      stop_bit = uart_txd;
      $display("TXD frame data=%02h stop=%0d", data, stop_bit);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] ports [6];
    logic [7:0] exp   [6];
    int low_seen;
    ports = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h80};
    exp   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    reset = 1'b0;
    repeat (3) @(negedge clk100);
    n_checks++;
    if (uart_txd !== 1'b1) $display("FAIL reset_txd got=%b exp=1", uart_txd); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      peek(ports[i], rd);
      n_checks++;
      if (rd !== exp[i]) $display("FAIL reset_port%02h got=%02h exp=%02h", ports[i], rd, exp[i]);
      else n_pass++;
    end
    @(negedge clk100);
    reset = 1'b1;
    @(negedge clk100);
    // A write to an unmapped port must not start a frame.
    io_write(8'h07, 8'h55);
    low_seen = 0;
    repeat (20) begin
      @(negedge clk100);
      if (uart_txd !== 1'b1) low_seen++;
    end
    n_checks++;
    if (low_seen != 0) $display("FAIL unmapped_write low_cycles got=%0d exp=0", low_seen); else n_pass++;
    peek(8'h03, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL unmapped_write_txfull got=%02h exp=00", rd); else n_pass++;
  endtask

  task automatic test_tx_frame();
    logic [7:0] bytes [2];
    logic [9:0] frame;
    bytes[0] = 8'hA5;
    bytes[1] = 8'($urandom);
    for (int b = 0; b < 2; b++) begin
      frame = {1'b1, bytes[b], 1'b0};
      io_write(8'h01, bytes[b]);
      n_checks++;
      if (uart_txd !== 1'b1) $display("FAIL tx_latency byte=%02h got=%b exp=1", bytes[b], uart_txd);
      else n_pass++;
      for (int k = 1; k <= 10 * CPB; k++) begin
        @(negedge clk100);
        n_checks++;
        if (uart_txd !== frame[(k - 1) / CPB])
          $display("FAIL tx_wave byte=%02h cycle=%0d got=%b exp=%b", bytes[b], k, uart_txd, frame[(k - 1) / CPB]);
        else n_pass++;
      end
      for (int k = 0; k < 8; k++) begin
        @(negedge clk100);
        n_checks++;
        if (uart_txd !== 1'b1) $display("FAIL tx_idle_after byte=%02h got=%b exp=1", bytes[b], uart_txd);
        else n_pass++;
      end
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp_q [$];
    logic [7:0] b, rd, data;
    logic stop_bit, found;
    int pending, low_seen;
    // 0xFF keeps the busy frame free of falling edges after its start bit.
    io_write(8'h01, 8'hFF);
    pending = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (pending < DEPTH) begin
        exp_q.push_back(b);
        pending++;
      end
      io_write(8'h01, b);
    end
    peek(8'h03, rd);
    n_checks++;
    if (rd !== 8'hFF) $display("FAIL tx_full_flag got=%02h exp=FF", rd); else n_pass++;
    while (exp_q.size() > 0) begin
      tx_capture(data, stop_bit, found);
      n_checks++;
      if (!found || data !== exp_q[0] || stop_bit !== 1'b1)
        $display("FAIL tx_full_frame got=%02h/stop%b/found%b exp=%02h/stop1", data, stop_bit, found, exp_q[0]);
      else n_pass++;
      void'(exp_q.pop_front());
    end
    low_seen = 0;
    repeat (60) begin
      @(negedge clk100);
      if (uart_txd !== 1'b1) low_seen++;
    end
    n_checks++;
    if (low_seen != 0) $display("FAIL tx_dropped_byte low_cycles got=%0d exp=0", low_seen); else n_pass++;
    peek(8'h03, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL tx_full_clear got=%02h exp=00", rd); else n_pass++;
  endtask

  task automatic test_rx_basic();
    logic [7:0] bytes [2];
    logic [7:0] rd;
    int waited;
    bytes[0] = 8'h3C;
    bytes[1] = 8'($urandom);
    for (int b = 0; b < 2; b++) begin
      uart_send(bytes[b], 1'b1);
      waited = 0;
      peek(8'h02, rd);
      while (rd !== 8'hFF && waited < 10) begin
        @(negedge clk100);
        peek(8'h02, rd);
        waited++;
      end
      n_checks++;
      if (rd !== 8'hFF) $display("FAIL rx_present byte=%02h got=%02h exp=FF", bytes[b], rd); else n_pass++;
      io_read(8'h01, rd);
      n_checks++;
      if (rd !== bytes[b]) $display("FAIL rx_data got=%02h exp=%02h", rd, bytes[b]); else n_pass++;
      peek(8'h02, rd);
      n_checks++;
      if (rd !== 8'h00) $display("FAIL rx_present_after_pop got=%02h exp=00", rd); else n_pass++;
      io_read(8'h01, rd);
      n_checks++;
      if (rd !== 8'h00) $display("FAIL rx_read_empty got=%02h exp=00", rd); else n_pass++;
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] exp_q [$];
    logic [7:0] b, rd;
    logic overrun;
    overrun = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else overrun = 1'b1;
      uart_send(b, 1'b1);
    end
    repeat (4) @(negedge clk100);
    io_read(8'h04, rd);
    n_checks++;
    if (rd !== {7'b0, overrun}) $display("FAIL rx_overrun_flag got=%02h exp=%02h", rd, {7'b0, overrun});
    else n_pass++;
    io_read(8'h04, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL rx_overrun_cleared got=%02h exp=00", rd); else n_pass++;
    while (exp_q.size() > 0) begin
      io_read(8'h01, rd);
      n_checks++;
      if (rd !== exp_q[0]) $display("FAIL rx_overrun_order got=%02h exp=%02h", rd, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front());
    end
    io_read(8'h01, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL rx_overrun_drained got=%02h exp=00", rd); else n_pass++;
  endtask

  task automatic test_frame_err();
    logic [7:0] rd;
    uart_send(8'($urandom), 1'b0);
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk100);
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk100);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk100);
    io_read(8'h04, rd);
    n_checks++;
    if (rd !== 8'h02) $display("FAIL frame_err_flag got=%02h exp=02", rd); else n_pass++;
    peek(8'h02, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL frame_err_fifo got=%02h exp=00", rd); else n_pass++;
    io_read(8'h04, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL glitch_no_event got=%02h exp=00", rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1, rd0, rd1, rd;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    uart_send(b0, 1'b1);
    uart_send(b1, 1'b1);
    repeat (4) @(negedge clk100);
    io_read(8'h01, rd0);
    io_read(8'h01, rd1);
    n_checks++;
    if (rd0 !== b0 || rd1 !== b1)
      $display("FAIL back_to_back_reads got=%02h,%02h exp=%02h,%02h", rd0, rd1, b0, b1);
    else n_pass++;
    peek(8'h02, rd);
    n_checks++;
    if (rd !== 8'h00) $display("FAIL back_to_back_empty got=%02h exp=00", rd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd, data, b;
    logic [7:0] ports [4];
    logic stop_bit, found;
    int low_seen;
    ports = '{8'h01, 8'h02, 8'h03, 8'h04};
    io_write(8'h01, 8'h00);
    fork
      uart_send(8'($urandom), 1'b1);
      begin
        repeat (14) @(negedge clk100);
        n_checks++;
        if (uart_txd !== 1'b0) $display("FAIL reset_mid_pre_txd got=%b exp=0", uart_txd); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (uart_txd !== 1'b1) $display("FAIL reset_async_txd got=%b exp=1", uart_txd); else n_pass++;
      end
    join
    for (int i = 0; i < 4; i++) begin
      peek(ports[i], rd);
      n_checks++;
      if (rd !== 8'h00) $display("FAIL reset_mid_port%02h got=%02h exp=00", ports[i], rd); else n_pass++;
    end
    @(negedge clk100);
    reset = 1'b1;
    low_seen = 0;
    repeat (50) begin
      @(negedge clk100);
      if (uart_txd !== 1'b1) low_seen++;
    end
    n_checks++;
    if (low_seen != 0) $display("FAIL reset_no_resume low_cycles got=%0d exp=0", low_seen); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      peek(ports[i], rd);
      n_checks++;
      if (rd !== 8'h00) $display("FAIL post_reset_port%02h got=%02h exp=00", ports[i], rd); else n_pass++;
    end
    b = 8'($urandom);
    io_write(8'h01, b);
    tx_capture(data, stop_bit, found);
    n_checks++;
    if (!found || data !== b || stop_bit !== 1'b1)
      $display("FAIL post_reset_tx got=%02h/stop%b/found%b exp=%02h/stop1", data, stop_bit, found, b);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    IO_port_ID = 8'h00; IO_write_data = 8'h00;
    IO_write_strobe = 1'b0; IO_read_strobe = 1'b0;
    uart_rxd = 1'b1;
    test_reset();
    test_tx_frame();
    test_tx_full();
    test_rx_basic();
    test_rx_overrun();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
